// File: rtl/graph_mem_scheduler.sv
// graph_mem_scheduler: shares the single-ported node SRAM between
// neighbor-info and feature-vector read streams.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   nb_* / fv_*         request streams {valid, node_id, pe_tag}
//   en                  issue enable (pushes still accepted when 0)
//   flush               synchronous clear of both request FIFOs
//   nb/fv_almost_full   FIFO count >= DEPTH-1
//   sram_cen/addr       read strobe and {type, node_id} address
//   sram_rdata          read data, one cycle after sram_cen
//   resp_*              registered response {valid, type, tag, data}
//   err_overflow        sticky: a push was dropped on a full FIFO
module graph_mem_scheduler #(
    parameter int NODE_W = 8,
    parameter int TAG_W  = 2,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nb_valid,
    input  logic [NODE_W-1:0] nb_node_id,
    input  logic [TAG_W-1:0]  nb_pe_tag,
    input  logic              fv_valid,
    input  logic [NODE_W-1:0] fv_node_id,
    input  logic [TAG_W-1:0]  fv_pe_tag,
    input  logic              en,
    input  logic              flush,
    output logic              nb_almost_full,
    output logic              fv_almost_full,
    output logic              sram_cen,
    output logic [NODE_W:0]   sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              resp_valid,
    output logic              resp_type,
    output logic [TAG_W-1:0]  resp_pe_tag,
    output logic [DATA_W-1:0] resp_data,
    output logic              err_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = NODE_W + TAG_W;
    localparam logic [DEPTH:0] L_FULL = (DEPTH+1)'(DEPTH);
    localparam logic [DEPTH:0] L_AF   = (DEPTH+1)'(DEPTH-1);
    localparam logic [DEPTH:0] L_ONE  = (DEPTH+1)'(1);
    localparam logic [PW-1:0]  L_PINC = PW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    logic [EW-1:0]    r_nb_mem [DEPTH];
    logic [EW-1:0]    r_fv_mem [DEPTH];
    logic [PW-1:0]    r_nb_wp, r_nb_rp, r_fv_wp, r_fv_rp;
    logic [DEPTH:0]   r_nb_cnt, r_fv_cnt;
    logic             r_last_fv;
    logic             r_err;
    state_t           r_state, w_next;
    logic             r_if_v, r_if_type;
    logic [TAG_W-1:0] r_if_tag;
    logic             r_resp_v, r_resp_type;
    logic [TAG_W-1:0] r_resp_tag;
    logic [DATA_W-1:0] r_resp_data;

    logic          w_nb_ne, w_fv_ne, w_nb_full, w_fv_full;
    logic          w_grant, w_sel_fv, w_nb_pop, w_fv_pop;
    logic          w_nb_push, w_fv_push, w_drop;
    logic [EW-1:0] w_nb_head, w_fv_head, w_head;

    assign w_nb_ne   = (r_nb_cnt != '0);
    assign w_fv_ne   = (r_fv_cnt != '0);
    assign w_nb_full = (r_nb_cnt == L_FULL);
    assign w_fv_full = (r_fv_cnt == L_FULL);
    assign w_nb_head = r_nb_mem[r_nb_rp];
    assign w_fv_head = r_fv_mem[r_fv_rp];

    // Serve FV only when it is the sole requester or neighbor went last.
    assign w_sel_fv = w_fv_ne & (~w_nb_ne | ~r_last_fv);
    assign w_grant  = en & ~flush & (w_nb_ne | w_fv_ne);
    assign w_nb_pop = w_grant & ~w_sel_fv;
    assign w_fv_pop = w_grant & w_sel_fv;
    assign w_head   = w_sel_fv ? w_fv_head : w_nb_head;

    // A full FIFO can still accept when it is popped in the same cycle.
    assign w_nb_push = nb_valid & ~flush & (~w_nb_full | w_nb_pop);
    assign w_fv_push = fv_valid & ~flush & (~w_fv_full | w_fv_pop);
    assign w_drop = (nb_valid & ~flush & w_nb_full & ~w_nb_pop)
                  | (fv_valid & ~flush & w_fv_full & ~w_fv_pop);

    assign sram_cen  = w_grant;
    assign sram_addr = w_grant ? {w_sel_fv, w_head[EW-1:TAG_W]} : '0;

    assign nb_almost_full = (r_nb_cnt >= L_AF);
    assign fv_almost_full = (r_fv_cnt >= L_AF);

    assign resp_valid   = r_resp_v;
    assign resp_type    = r_resp_type;
    assign resp_pe_tag  = r_resp_tag;
    assign resp_data    = r_resp_data;
    assign err_overflow = r_err;

    always_ff @(posedge clk) begin
        if (w_nb_push) r_nb_mem[r_nb_wp] <= {nb_node_id, nb_pe_tag};
        if (w_fv_push) r_fv_mem[r_fv_wp] <= {fv_node_id, fv_pe_tag};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nb_wp  <= '0;
            r_nb_rp  <= '0;
            r_nb_cnt <= '0;
            r_fv_wp  <= '0;
            r_fv_rp  <= '0;
            r_fv_cnt <= '0;
        end else if (flush) begin
            r_nb_wp  <= '0;
            r_nb_rp  <= '0;
            r_nb_cnt <= '0;
            r_fv_wp  <= '0;
            r_fv_rp  <= '0;
            r_fv_cnt <= '0;
        end else begin
            if (w_nb_push) r_nb_wp <= r_nb_wp + L_PINC;
            if (w_nb_pop)  r_nb_rp <= r_nb_rp + L_PINC;
            if (w_fv_push) r_fv_wp <= r_fv_wp + L_PINC;
            if (w_fv_pop)  r_fv_rp <= r_fv_rp + L_PINC;
            case ({w_nb_push, w_nb_pop})
                2'b10:   r_nb_cnt <= r_nb_cnt + L_ONE;
                2'b01:   r_nb_cnt <= r_nb_cnt - L_ONE;
                default: r_nb_cnt <= r_nb_cnt;
            endcase
            case ({w_fv_push, w_fv_pop})
                2'b10:   r_fv_cnt <= r_fv_cnt + L_ONE;
                2'b01:   r_fv_cnt <= r_fv_cnt - L_ONE;
                default: r_fv_cnt <= r_fv_cnt;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_next = ISSUE;
            ISSUE: begin
                if (!en)                          w_next = HOLD;
                else if (!(w_nb_ne || w_fv_ne))   w_next = IDLE;
            end
            HOLD: begin
                if (en) w_next = (w_nb_ne || w_fv_ne) ? ISSUE : IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last_fv   <= 1'b1;
            r_err       <= 1'b0;
            r_if_v      <= 1'b0;
            r_if_type   <= 1'b0;
            r_if_tag    <= '0;
            r_resp_v    <= 1'b0;
            r_resp_type <= 1'b0;
            r_resp_tag  <= '0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= r_err | w_drop;
            r_if_v  <= w_grant;
            if (w_grant) begin
                r_last_fv <= w_sel_fv;
                r_if_type <= w_sel_fv;
                r_if_tag  <= w_head[TAG_W-1:0];
            end
            // Pair the in-flight tag with the data returned this cycle.
            r_resp_v <= r_if_v;
            if (r_if_v) begin
                r_resp_type <= r_if_type;
                r_resp_tag  <= r_if_tag;
                r_resp_data <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_graph_mem_scheduler.sv
// Testbench for graph_mem_scheduler: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_graph_mem_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        nb_valid, fv_valid, en, flush;
    logic [7:0]  nb_node_id, fv_node_id;
    logic [1:0]  nb_pe_tag, fv_pe_tag;
    logic        nb_almost_full, fv_almost_full;
    logic        sram_cen;
    logic [8:0]  sram_addr;
    logic [15:0] sram_rdata = '0;
    logic        resp_valid, resp_type;
    logic [1:0]  resp_pe_tag;
    logic [15:0] resp_data;
    logic        err_overflow;

    graph_mem_scheduler dut (
        .clk(clk), .reset(reset),
        .nb_valid(nb_valid), .nb_node_id(nb_node_id), .nb_pe_tag(nb_pe_tag),
        .fv_valid(fv_valid), .fv_node_id(fv_node_id), .fv_pe_tag(fv_pe_tag),
        .en(en), .flush(flush),
        .nb_almost_full(nb_almost_full), .fv_almost_full(fv_almost_full),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .resp_valid(resp_valid), .resp_type(resp_type),
        .resp_pe_tag(resp_pe_tag), .resp_data(resp_data),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [8:0] a);
        return 16'(a) * 16'd97 + 16'h3C5A;
    endfunction

    always @(posedge clk) if (sram_cen) sram_rdata <= memf(sram_addr);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_cen = 0;
    int n_rsp = 0;

    typedef struct packed { logic [7:0] n; logic [1:0] t; } req_t;
    typedef struct { int at; logic ty; logic [1:0] tag; logic [15:0] d; } rsp_t;
    req_t mq_nb[$];
    req_t mq_fv[$];
    rsp_t mq_rsp[$];
    logic m_last = 1'b1;
    logic m_err  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_nb.delete();
        mq_fv.delete();
        mq_rsp.delete();
        m_last = 1'b1;
        m_err  = 1'b0;
        cyc    = 0;
    endtask

    task automatic model_step();
        logic g, ty;
        logic [8:0] a;
        req_t r;
        rsp_t e;
        int nbs, fvs;
        nbs = mq_nb.size();
        fvs = mq_fv.size();
        g  = en && !flush && (nbs + fvs > 0);
        ty = (nbs > 0 && fvs > 0) ? ~m_last : (fvs > 0);
        a  = '0;
        r  = '0;
        if (g) begin
            r = ty ? mq_fv[0] : mq_nb[0];
            a = {ty, r.n};
        end
        chk("m_cen", 32'(sram_cen), 32'(g));
        chk("m_addr", 32'(sram_addr), 32'(a));
        chk("m_nb_af", 32'(nb_almost_full), 32'(nbs >= DEPTH-1));
        chk("m_fv_af", 32'(fv_almost_full), 32'(fvs >= DEPTH-1));
        chk("m_err", 32'(err_overflow), 32'(m_err));
        if (mq_rsp.size() > 0 && mq_rsp[0].at == cyc) begin
            e = mq_rsp.pop_front();
            chk("m_rv", 32'(resp_valid), 32'd1);
            chk("m_rtype", 32'(resp_type), 32'(e.ty));
            chk("m_rtag", 32'(resp_pe_tag), 32'(e.tag));
            chk("m_rdata", 32'(resp_data), 32'(e.d));
        end else begin
            chk("m_rv", 32'(resp_valid), 32'd0);
        end
        if (sram_cen) n_cen++;
        if (resp_valid) n_rsp++;
        if (g) begin
            if (ty) void'(mq_fv.pop_front());
            else    void'(mq_nb.pop_front());
            m_last = ty;
            mq_rsp.push_back('{cyc + 2, ty, r.t, memf(a)});
        end
        if (flush) begin
            mq_nb.delete();
            mq_fv.delete();
        end else begin
            if (nb_valid) begin
                if (mq_nb.size() < DEPTH) mq_nb.push_back({nb_node_id, nb_pe_tag});
                else m_err = 1'b1;
            end
            if (fv_valid) begin
                if (mq_fv.size() < DEPTH) mq_fv.push_back({fv_node_id, fv_pe_tag});
                else m_err = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic nbv, input logic [7:0] nbn,
                         input logic [1:0] nbt, input logic fvv,
                         input logic [7:0] fvn, input logic [1:0] fvt,
                         input logic e, input logic fl);
        nb_valid = nbv; nb_node_id = nbn; nb_pe_tag = nbt;
        fv_valid = fvv; fv_node_id = fvn; fv_pe_tag = fvt;
        en = e; flush = fl;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic nbv, input logic [7:0] nbn,
                        input logic [1:0] nbt, input logic fvv,
                        input logic [7:0] fvn, input logic [1:0] fvt,
                        input logic e, input logic fl);
        drive(nbv, nbn, nbt, fvv, fvn, fvt, e, fl);
        model_step();
        adv();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cen"}, 32'(sram_cen), 32'd0);
        chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_rv"}, 32'(resp_valid), 32'd0);
        chk({tag, "_rtype"}, 32'(resp_type), 32'd0);
        chk({tag, "_rtag"}, 32'(resp_pe_tag), 32'd0);
        chk({tag, "_rdata"}, 32'(resp_data), 32'd0);
        chk({tag, "_err"}, 32'(err_overflow), 32'd0);
        chk({tag, "_nbaf"}, 32'(nb_almost_full), 32'd0);
        chk({tag, "_fvaf"}, 32'(fv_almost_full), 32'd0);
    endtask

    typedef struct {
        logic nbv; logic [7:0] nbn; logic [1:0] nbt; logic en;
        logic ecen; logic [8:0] ea; logic erv; logic [1:0] etag;
        logic eerr; logic enaf;
    } vec_t;

    function automatic vec_t mk(input logic nbv, input logic [7:0] nbn,
                                input logic [1:0] nbt, input logic e,
                                input logic ecen, input logic [8:0] ea,
                                input logic erv, input logic [1:0] etag,
                                input logic eerr, input logic enaf);
        vec_t v;
        v.nbv = nbv; v.nbn = nbn; v.nbt = nbt; v.en = e;
        v.ecen = ecen; v.ea = ea; v.erv = erv; v.etag = etag;
        v.eerr = eerr; v.enaf = enaf;
        return v;
    endfunction

    vec_t tbl[18];
    logic order[$];
    int first_cen;
    int base_cen, base_rsp;

    initial begin
        // single request latency, then 5 pushes into a 4-deep FIFO
        tbl[0]  = mk(1, 8'h12, 2, 1, 0, 9'h000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 8'h00, 0, 1, 1, 9'h012, 0, 0, 0, 0);
        tbl[2]  = mk(0, 8'h00, 0, 1, 0, 9'h000, 0, 0, 0, 0);
        tbl[3]  = mk(0, 8'h00, 0, 1, 0, 9'h000, 1, 2, 0, 0);
        tbl[4]  = mk(0, 8'h00, 0, 1, 0, 9'h000, 0, 0, 0, 0);
        tbl[5]  = mk(1, 8'h20, 0, 0, 0, 9'h000, 0, 0, 0, 0);
        tbl[6]  = mk(1, 8'h21, 1, 0, 0, 9'h000, 0, 0, 0, 0);
        tbl[7]  = mk(1, 8'h22, 2, 0, 0, 9'h000, 0, 0, 0, 0);
        tbl[8]  = mk(1, 8'h23, 3, 0, 0, 9'h000, 0, 0, 0, 1);
        tbl[9]  = mk(1, 8'h24, 0, 0, 0, 9'h000, 0, 0, 0, 1);
        tbl[10] = mk(0, 8'h00, 0, 0, 0, 9'h000, 0, 0, 1, 1);
        tbl[11] = mk(0, 8'h00, 0, 1, 1, 9'h020, 0, 0, 1, 1);
        tbl[12] = mk(0, 8'h00, 0, 1, 1, 9'h021, 0, 0, 1, 1);
        tbl[13] = mk(0, 8'h00, 0, 1, 1, 9'h022, 1, 0, 1, 0);
        tbl[14] = mk(0, 8'h00, 0, 1, 1, 9'h023, 1, 1, 1, 0);
        tbl[15] = mk(0, 8'h00, 0, 1, 0, 9'h000, 1, 2, 1, 0);
        tbl[16] = mk(0, 8'h00, 0, 1, 0, 9'h000, 1, 3, 1, 0);
        tbl[17] = mk(0, 8'h00, 0, 1, 0, 9'h000, 0, 0, 1, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].nbv, tbl[i].nbn, tbl[i].nbt, 0, 0, 0, tbl[i].en, 0);
            model_step();
            chk($sformatf("t%0d_cen", i), 32'(sram_cen), 32'(tbl[i].ecen));
            chk($sformatf("t%0d_addr", i), 32'(sram_addr), 32'(tbl[i].ea));
            chk($sformatf("t%0d_rv", i), 32'(resp_valid), 32'(tbl[i].erv));
            if (tbl[i].erv) begin
                chk($sformatf("t%0d_rtag", i), 32'(resp_pe_tag), 32'(tbl[i].etag));
                chk($sformatf("t%0d_rtype", i), 32'(resp_type), 32'd0);
            end
            chk($sformatf("t%0d_err", i), 32'(err_overflow), 32'(tbl[i].eerr));
            chk($sformatf("t%0d_naf", i), 32'(nb_almost_full), 32'(tbl[i].enaf));
            adv();
        end

        // reset while a read is in flight
        tick(1, 8'h77, 1, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        reset = 1'b1;
        #1;
        chk_all_zero("rstfl");
        adv();
        chk("rstfl_rv_next", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        model_reset();

        // both streams push for 4 cycles; expect nb,fv alternation
        first_cen = -1;
        base_rsp = n_rsp;
        for (int i = 0; i < 12; i++) begin
            if (i < 4)
                drive(1, 8'h50 + 8'(i), 2'(i), 1, 8'h60 + 8'(i), 2'(3 - i), 1, 0);
            else
                drive(0, 0, 0, 0, 0, 0, 1, 0);
            model_step();
            if (sram_cen) begin
                order.push_back(sram_addr[8]);
                if (first_cen < 0) first_cen = i;
            end
            adv();
        end
        chk("rr_first_cen", 32'(first_cen), 32'd1);
        chk("rr_grants", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
        chk("rr_resps", 32'(n_rsp - base_rsp), 32'd8);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) tick(1, 8'h30 + 8'(i), 2'(i), 0, 0, 0, 0, 0);
        base_cen = n_cen;
        base_rsp = n_rsp;
        tick(1, 8'h34, 0, 0, 0, 0, 1, 0);
        chk("fpp_err", 32'(err_overflow), 32'd0);
        chk("fpp_af", 32'(nb_almost_full), 32'd1);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0, 0, 1, 0);
        chk("fpp_cen", 32'(n_cen - base_cen), 32'd5);
        chk("fpp_rsp", 32'(n_rsp - base_rsp), 32'd5);

        // flush one cycle after an issue with 3 entries still queued
        for (int i = 0; i < 4; i++) tick(1, 8'h40 + 8'(i), 2'(i), 0, 0, 0, 0, 0);
        base_cen = n_cen;
        base_rsp = n_rsp;
        tick(0, 0, 0, 0, 0, 0, 1, 0);
        tick(1, 8'h99, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0, 1, 0);
        chk("fl_cen", 32'(n_cen - base_cen), 32'd1);
        chk("fl_rsp", 32'(n_rsp - base_rsp), 32'd1);
        chk("fl_err", 32'(err_overflow), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rand_drained", 32'(mq_rsp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
